// File: rtl/sfb_pkg.sv
// Shared types, widths and derived-constant helpers for the frame buffer
// line-fetch scheduler.
package sfb_pkg;

    localparam int ADDR_W   = 32;
    localparam int LEN_W    = 6;
    localparam int POS_W    = 14;
    localparam int USED_W   = 11;
    localparam int CREDIT_W = 12;
    localparam int BEATS_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        REQ    = 2'd2
    } fetch_state_t;

    // Beats needed to carry one visible line, rounded up to whole beats.
    function automatic int line_beats(input int h_visible, input int bpp_bytes,
                                      input int beat_bytes);
        return (h_visible * bpp_bytes + beat_bytes - 1) / beat_bytes;
    endfunction

    // Fetching runs one line ahead of display.
    function automatic int fetch_first(input int v_vis_begin);
        return v_vis_begin - 1;
    endfunction

    function automatic int fetch_last(input int v_vis_begin, input int v_visible);
        return v_vis_begin + v_visible - 2;
    endfunction

endpackage

// File: rtl/sfb_credit_counter.sv
// Tracks beats requested but not yet written into the line FIFO, and decides
// whether the FIFO has room for the next burst.
module sfb_credit_counter
    import sfb_pkg::*;
#(
    parameter int FIFO_DEPTH = 1024
) (
    input  logic                pixel_clock,
    input  logic                nrst,
    input  logic                accept,
    input  logic [LEN_W-1:0]    accept_len,
    input  logic                rd_beat,
    input  logic [USED_W-1:0]   fifo_used,
    input  logic [LEN_W-1:0]    need_len,
    output logic [CREDIT_W-1:0] outstanding,
    output logic                credit_ok
);

    logic [CREDIT_W-1:0] credit;

    // Free FIFO space not already promised to in-flight beats (wraps as unsigned).
    always_comb begin
        credit    = CREDIT_W'(FIFO_DEPTH) - CREDIT_W'(fifo_used) - outstanding;
        credit_ok = (credit >= CREDIT_W'(need_len));
    end

    // Accepted bursts add their length; each returned beat retires one.
    always_ff @(posedge pixel_clock or negedge nrst) begin
        if (!nrst) begin
            outstanding <= '0;
        end else begin
            case ({accept, rd_beat})
                2'b10: outstanding <= outstanding + CREDIT_W'(accept_len);
                2'b01: if (outstanding != '0) outstanding <= outstanding - CREDIT_W'(1);
                2'b11: outstanding <= outstanding + CREDIT_W'(accept_len) - CREDIT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: rtl/sfb_fetch_scheduler.sv
// Line-fetch scheduler: issues burst reads one line ahead of display, gated
// by FIFO credit, and manages the front buffer swap and FIFO flush per frame.
module sfb_fetch_scheduler
    import sfb_pkg::*;
#(
    parameter int H_VISIBLE   = 1920,
    parameter int V_VISIBLE   = 1080,
    parameter int V_VIS_BEGIN = 41,
    parameter int BPP_BYTES   = 4,
    parameter int BEAT_BYTES  = 16,
    parameter int BURST_BEATS = 32,
    parameter int FIFO_DEPTH  = 1024,
    parameter int LINE_STRIDE = 7680
) (
    input  logic              pixel_clock,
    input  logic              nrst,
    input  logic [POS_W-1:0]  timing_h_pos,
    input  logic [POS_W-1:0]  timing_v_pos,
    input  logic [ADDR_W-1:0] buf0_base,
    input  logic [ADDR_W-1:0] buf1_base,
    input  logic              swap_req,
    input  logic [USED_W-1:0] fifo_used,
    input  logic              rd_beat,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic [LEN_W-1:0]  req_len,
    output logic              fifo_flush,
    output logic              cur_buf,
    output logic              swap_ack,
    output logic              underrun
);

    localparam int LINE_BEATS  = line_beats(H_VISIBLE, BPP_BYTES, BEAT_BYTES);
    localparam logic [POS_W-1:0] FIRST_POS = POS_W'(fetch_first(V_VIS_BEGIN));
    localparam logic [POS_W-1:0] LAST_POS  = POS_W'(fetch_last(V_VIS_BEGIN, V_VISIBLE));

    fetch_state_t        state;
    logic                swap_pending;
    logic                flush_pending;
    logic                restart;
    logic [ADDR_W-1:0]   line_addr;
    logic [ADDR_W-1:0]   fetch_addr;
    logic [BEATS_W-1:0]  rem_beats;

    logic                frame_start;
    logic                trigger;
    logic                trigger_ok;
    logic                accept;
    logic [LEN_W-1:0]    next_len;
    logic [BEATS_W-1:0]  rem_after;
    logic [ADDR_W-1:0]   new_line_addr;
    logic [ADDR_W-1:0]   burst_bytes;
    logic [CREDIT_W-1:0] outstanding;
    logic                credit_ok;

    // Raster decode, next burst sizing and address arithmetic.
    always_comb begin
        frame_start   = (timing_h_pos == '0) && (timing_v_pos == '0);
        trigger       = (timing_h_pos == '0) && (timing_v_pos >= FIRST_POS)
                        && (timing_v_pos <= LAST_POS);
        trigger_ok    = trigger && !flush_pending;
        accept        = req_valid && req_ready;
        next_len      = (rem_beats < BEATS_W'(BURST_BEATS)) ? LEN_W'(rem_beats)
                                                            : LEN_W'(BURST_BEATS);
        rem_after     = rem_beats - BEATS_W'(req_len);
        burst_bytes   = ADDR_W'(req_len) * ADDR_W'(BEAT_BYTES);
        new_line_addr = (timing_v_pos == FIRST_POS) ? (cur_buf ? buf1_base : buf0_base)
                                                    : line_addr + ADDR_W'(LINE_STRIDE);
    end

    sfb_credit_counter #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_credit (
        .pixel_clock (pixel_clock),
        .nrst        (nrst),
        .accept      (accept),
        .accept_len  (req_len),
        .rd_beat     (rd_beat),
        .fifo_used   (fifo_used),
        .need_len    (next_len),
        .outstanding (outstanding),
        .credit_ok   (credit_ok)
    );

    // Frame-start bookkeeping: buffer swap and the once-per-frame FIFO flush.
    always_ff @(posedge pixel_clock or negedge nrst) begin
        if (!nrst) begin
            cur_buf       <= 1'b0;
            swap_ack      <= 1'b0;
            swap_pending  <= 1'b0;
            flush_pending <= 1'b0;
            fifo_flush    <= 1'b0;
        end else begin
            swap_ack   <= 1'b0;
            fifo_flush <= 1'b0;
            if (frame_start) begin
                if (swap_pending || swap_req) begin
                    cur_buf  <= ~cur_buf;
                    swap_ack <= 1'b1;
                end
                swap_pending  <= 1'b0;
                flush_pending <= 1'b1;
            end else begin
                if (swap_req) swap_pending <= 1'b1;
                if (flush_pending && (state == IDLE) && (outstanding == '0)) begin
                    fifo_flush    <= 1'b1;
                    flush_pending <= 1'b0;
                end
            end
        end
    end

    // Fetch FSM: wait for credit, hold each request until accepted, restart on late triggers.
    always_ff @(posedge pixel_clock or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            req_valid  <= 1'b0;
            req_addr   <= '0;
            req_len    <= '0;
            underrun   <= 1'b0;
            restart    <= 1'b0;
            line_addr  <= '0;
            fetch_addr <= '0;
            rem_beats  <= '0;
        end else begin
            if (trigger && (flush_pending || (state != IDLE))) underrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (trigger_ok) begin
                        line_addr  <= new_line_addr;
                        fetch_addr <= new_line_addr;
                        rem_beats  <= BEATS_W'(LINE_BEATS);
                        state      <= CREDIT;
                    end
                end
                CREDIT: begin
                    if (trigger_ok) begin
                        line_addr  <= new_line_addr;
                        fetch_addr <= new_line_addr;
                        rem_beats  <= BEATS_W'(LINE_BEATS);
                    end else if (credit_ok) begin
                        req_valid <= 1'b1;
                        req_addr  <= fetch_addr;
                        req_len   <= next_len;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        restart   <= 1'b0;
                        if (trigger_ok) begin
                            line_addr  <= new_line_addr;
                            fetch_addr <= new_line_addr;
                            rem_beats  <= BEATS_W'(LINE_BEATS);
                            state      <= CREDIT;
                        end else if (restart) begin
                            state <= CREDIT;
                        end else begin
                            fetch_addr <= fetch_addr + burst_bytes;
                            rem_beats  <= rem_after;
                            state      <= (rem_after != '0) ? CREDIT : IDLE;
                        end
                    end else if (trigger_ok) begin
                        line_addr  <= new_line_addr;
                        fetch_addr <= new_line_addr;
                        rem_beats  <= BEATS_W'(LINE_BEATS);
                        restart    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sfb_fetch_scheduler.sv
// Directed bench for the line-fetch scheduler: a default-size instance plus a
// narrow-line instance (H_VISIBLE=100) sharing the same raster and FIFO inputs.
module tb_sfb_fetch_scheduler;

    localparam logic [31:0] B0 = 32'h1000_0000;
    localparam logic [31:0] B1 = 32'h2000_0000;
    localparam int STRIDE      = 7680;
    localparam int BURST_BYTES = 512;

    typedef struct {
        logic [13:0] v;
        int          exp_reqs;
        logic [31:0] exp_first;
    } line_vec_t;

    logic        pixel_clock;
    logic        nrst;
    logic [13:0] timing_h_pos;
    logic [13:0] timing_v_pos;
    logic        swap_req;
    logic [10:0] fifo_used;
    logic        rd_beat;
    logic        req_ready;

    logic        req_valid;
    logic [31:0] req_addr;
    logic [5:0]  req_len;
    logic        fifo_flush;
    logic        cur_buf;
    logic        swap_ack;
    logic        underrun;

    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic [5:0]  s_req_len;
    logic        s_fifo_flush;
    logic        s_cur_buf;
    logic        s_swap_ack;
    logic        s_underrun;

    int n_checks = 0;
    int n_fail   = 0;
    int owed     = 0;

    logic [31:0] big_addr_q[$];
    logic [5:0]  big_len_q[$];
    logic [31:0] small_addr_q[$];
    logic [5:0]  small_len_q[$];

    sfb_fetch_scheduler dut (
        .pixel_clock  (pixel_clock),
        .nrst         (nrst),
        .timing_h_pos (timing_h_pos),
        .timing_v_pos (timing_v_pos),
        .buf0_base    (B0),
        .buf1_base    (B1),
        .swap_req     (swap_req),
        .fifo_used    (fifo_used),
        .rd_beat      (rd_beat),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .fifo_flush   (fifo_flush),
        .cur_buf      (cur_buf),
        .swap_ack     (swap_ack),
        .underrun     (underrun)
    );

    sfb_fetch_scheduler #(.H_VISIBLE(100)) dut_small (
        .pixel_clock  (pixel_clock),
        .nrst         (nrst),
        .timing_h_pos (timing_h_pos),
        .timing_v_pos (timing_v_pos),
        .buf0_base    (B0),
        .buf1_base    (B1),
        .swap_req     (swap_req),
        .fifo_used    (fifo_used),
        .rd_beat      (rd_beat),
        .req_valid    (s_req_valid),
        .req_ready    (req_ready),
        .req_addr     (s_req_addr),
        .req_len      (s_req_len),
        .fifo_flush   (s_fifo_flush),
        .cur_buf      (s_cur_buf),
        .swap_ack     (s_swap_ack),
        .underrun     (s_underrun)
    );

    initial begin
        pixel_clock = 1'b0;
        forever #5 pixel_clock = ~pixel_clock;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Request log and instant-drain memory model: accepted beats return one per cycle.
    initial begin
        rd_beat = 1'b0;
        forever begin
            @(negedge pixel_clock);
            if (!nrst) begin
                owed    = 0;
                rd_beat = 1'b0;
            end else begin
                if (req_valid && req_ready) begin
                    big_addr_q.push_back(req_addr);
                    big_len_q.push_back(req_len);
                    owed += int'(req_len);
                end
                if (s_req_valid && req_ready) begin
                    small_addr_q.push_back(s_req_addr);
                    small_len_q.push_back(s_req_len);
                end
                if (owed > 0) begin
                    rd_beat = 1'b1;
                    owed--;
                end else begin
                    rd_beat = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge pixel_clock);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One-cycle h_pos==0 pulse on line v, then move off column 0.
    task automatic apply_stimulus(input logic [13:0] v);
        timing_h_pos = 14'd0;
        timing_v_pos = v;
        tick();
        timing_h_pos = 14'd1;
    endtask

    task automatic clear_logs();
        big_addr_q.delete();
        big_len_q.delete();
        small_addr_q.delete();
        small_len_q.delete();
    endtask

    task automatic wait_requests(input int n);
        int waited = 0;
        while (big_addr_q.size() < n && waited < 300) begin
            tick();
            waited++;
        end
        repeat (6) tick();
    endtask

    task automatic wait_drain();
        int waited = 0;
        while (owed != 0 && waited < 2000) begin
            tick();
            waited++;
        end
        repeat (2) tick();
        check_output("drain_done", (owed == 0), 1);
    endtask

    task automatic run_line(input logic [13:0] v, input int exp_reqs,
                            input logic [31:0] exp_first);
        clear_logs();
        apply_stimulus(v);
        wait_requests(exp_reqs);
        check_output($sformatf("line%0d_count", v), big_addr_q.size(), exp_reqs);
        for (int k = 0; k < exp_reqs && k < big_addr_q.size(); k++) begin
            check_output($sformatf("line%0d_addr%0d", v, k), big_addr_q[k],
                         exp_first + 32'(k * BURST_BYTES));
            check_output($sformatf("line%0d_len%0d", v, k), 32'(big_len_q[k]), 32);
        end
        check_output($sformatf("small%0d_count", v), small_addr_q.size(),
                     (exp_reqs > 0) ? 1 : 0);
        if (exp_reqs > 0 && small_addr_q.size() > 0) begin
            check_output($sformatf("small%0d_addr", v), small_addr_q[0], exp_first);
            check_output($sformatf("small%0d_len", v), 32'(small_len_q[0]), 25);
        end
        wait_drain();
        check_output($sformatf("line%0d_idle", v), req_valid, 0);
    endtask

    initial begin
        line_vec_t vec_table[6];
        logic [31:0] held_addr;

        vec_table[0] = '{14'd40,   15, B0};
        vec_table[1] = '{14'd41,   15, B0 + 32'(STRIDE)};
        vec_table[2] = '{14'd42,   15, B0 + 32'(2 * STRIDE)};
        vec_table[3] = '{14'd1119, 15, B0 + 32'(3 * STRIDE)};
        vec_table[4] = '{14'd1120, 0,  32'h0};
        vec_table[5] = '{14'd39,   0,  32'h0};

        nrst         = 1'b0;
        timing_h_pos = 14'd1;
        timing_v_pos = 14'd1;
        swap_req     = 1'b0;
        fifo_used    = 11'd0;
        req_ready    = 1'b1;
        repeat (3) tick();

        // Reset values.
        check_output("rst_req_valid", req_valid, 0);
        check_output("rst_req_addr", req_addr, 0);
        check_output("rst_req_len", 32'(req_len), 0);
        check_output("rst_fifo_flush", fifo_flush, 0);
        check_output("rst_cur_buf", cur_buf, 0);
        check_output("rst_swap_ack", swap_ack, 0);
        check_output("rst_underrun", underrun, 0);
        nrst = 1'b1;
        tick();

        // Frame start without a swap: flush one cycle after the pending flag.
        apply_stimulus(14'd0);
        timing_v_pos = 14'd1;
        check_output("fs0_cur_buf", cur_buf, 0);
        check_output("fs0_swap_ack", swap_ack, 0);
        check_output("fs0_flush_early", fifo_flush, 0);
        tick();
        check_output("fs0_flush", fifo_flush, 1);
        tick();
        check_output("fs0_flush_end", fifo_flush, 0);

        // Table of lines: first line, strided lines, last fetch line, out-of-window lines.
        for (int i = 0; i < 6; i++)
            run_line(vec_table[i].v, vec_table[i].exp_reqs, vec_table[i].exp_first);

        // Credit gating: 1024-1000 = 24 beats free is not enough; 992 gives exactly 32.
        clear_logs();
        fifo_used = 11'd1000;
        apply_stimulus(14'd43);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output($sformatf("stall_valid%0d", i), req_valid, 0);
        end
        fifo_used = 11'd992;
        tick();
        check_output("credit_valid", req_valid, 1);
        check_output("credit_addr", req_addr, B0 + 32'(4 * STRIDE));
        check_output("credit_len", 32'(req_len), 32);
        fifo_used = 11'd0;
        wait_requests(15);
        check_output("credit_count", big_addr_q.size(), 15);
        if (big_addr_q.size() == 15)
            check_output("credit_last_addr", big_addr_q[14],
                         B0 + 32'(4 * STRIDE) + 32'(14 * BURST_BYTES));
        wait_drain();
        check_output("no_underrun_yet", underrun, 0);

        // Swap requested mid-frame takes effect one cycle after frame start.
        timing_h_pos = 14'd5;
        timing_v_pos = 14'd500;
        swap_req     = 1'b1;
        tick();
        swap_req = 1'b0;
        check_output("swap_pend_cur_buf", cur_buf, 0);
        check_output("swap_pend_ack", swap_ack, 0);
        apply_stimulus(14'd0);
        timing_v_pos = 14'd1;
        check_output("swap_cur_buf", cur_buf, 1);
        check_output("swap_ack_pulse", swap_ack, 1);
        tick();
        check_output("swap_ack_end", swap_ack, 0);
        check_output("swap_flush", fifo_flush, 1);
        tick();
        run_line(14'd40, 15, B1);

        // Stalled master: request held stable, next trigger flags underrun and restarts.
        clear_logs();
        req_ready = 1'b0;
        apply_stimulus(14'd41);
        tick();
        check_output("hold_valid", req_valid, 1);
        check_output("hold_addr", req_addr, B1 + 32'(STRIDE));
        check_output("hold_len", 32'(req_len), 32);
        held_addr = req_addr;
        repeat (20) tick();
        check_output("hold_addr_late", req_addr, held_addr);
        check_output("hold_no_underrun", underrun, 0);
        apply_stimulus(14'd42);
        check_output("late_trigger_underrun", underrun, 1);
        check_output("late_trigger_valid", req_valid, 1);
        check_output("late_trigger_addr", req_addr, B1 + 32'(STRIDE));
        req_ready = 1'b1;
        wait_requests(16);
        check_output("restart_count", big_addr_q.size(), 16);
        if (big_addr_q.size() == 16) begin
            check_output("restart_old_addr", big_addr_q[0], B1 + 32'(STRIDE));
            check_output("restart_new_addr", big_addr_q[1], B1 + 32'(2 * STRIDE));
            check_output("restart_last_addr", big_addr_q[15],
                         B1 + 32'(2 * STRIDE) + 32'(14 * BURST_BYTES));
        end
        wait_drain();

        // Asynchronous reset while a request is waiting for the master.
        req_ready = 1'b0;
        apply_stimulus(14'd43);
        tick();
        check_output("pre_reset_valid", req_valid, 1);
        #2;
        nrst = 1'b0;
        #1;
        check_output("arst_req_valid", req_valid, 0);
        check_output("arst_req_addr", req_addr, 0);
        check_output("arst_req_len", 32'(req_len), 0);
        check_output("arst_fifo_flush", fifo_flush, 0);
        check_output("arst_cur_buf", cur_buf, 0);
        check_output("arst_swap_ack", swap_ack, 0);
        check_output("arst_underrun", underrun, 0);
        req_ready = 1'b1;
        repeat (2) tick();
        nrst = 1'b1;
        tick();

        // Swap pulse coinciding with frame start, then a trigger while the flush is pending.
        timing_h_pos = 14'd0;
        timing_v_pos = 14'd0;
        swap_req     = 1'b1;
        tick();
        swap_req = 1'b0;
        check_output("fs_swap_cur_buf", cur_buf, 1);
        check_output("fs_swap_ack", swap_ack, 1);
        check_output("fs_no_underrun", underrun, 0);
        apply_stimulus(14'd40);
        check_output("flush_trigger_underrun", underrun, 1);
        check_output("flush_trigger_flush", fifo_flush, 1);
        check_output("flush_trigger_ack_end", swap_ack, 0);
        repeat (4) tick();
        check_output("flush_trigger_ignored", req_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
